// File: rtl/memory_slave_if.sv
// Request/response handshake between Core (master) and its memory (slave).
// Word addresses are 32 bits wide; the data width is set by the instantiating design.
interface Memory #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           m_address;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_write;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output m_address, m_data, m_write, m_valid, s_ready,
    input  m_ready, s_data, s_valid
  );

  modport slave (
    input  m_address, m_data, m_write, m_valid, s_ready,
    output m_ready, s_data, s_valid
  );
endinterface

// File: rtl/memory_slave.sv
// Single-port synchronous RAM on the slave side of Memory: fixed-latency read pipeline
// feeding an in-order response FIFO, with credit-based request flow control.
module memory_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input logic  clock,
  input logic  reset,
  Memory.slave memory
);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic                  accept;
  logic                  pop;
  logic                  push;
  logic [ADDR_WIDTH-1:0] index;
  logic                  unused_address_bits;
  logic [CNT_W-1:0]      outstanding;

  // Upper address bits are ignored, so addresses alias onto the RAM.
  assign index               = memory.m_address[ADDR_WIDTH-1:0];
  assign unused_address_bits = ^memory.m_address[31:ADDR_WIDTH];

  // Credit check uses registered state only, so the FIFO can never overflow.
  assign memory.m_ready = (outstanding < CNT_W'(RESP_DEPTH)) && !reset;
  assign accept         = memory.m_valid && memory.m_ready;
  assign pop            = memory.s_valid && memory.s_ready;

  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] ram_q;

  always_ff @(posedge clock) begin
    if (accept && memory.m_write)
      ram[index] <= memory.m_data;
    ram_q <= ram[index];
  end

  // Stage 0 carries the write data and the read/write flag; a read picks up ram_q there.
  logic [LATENCY-1:0]    pipe_valid;
  logic                  pipe_write;
  logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
  logic [DATA_WIDTH-1:0] stage_out [LATENCY];

  always_comb begin
    stage_out[0] = pipe_write ? pipe_data[0] : ram_q;
    for (int i = 1; i < LATENCY; i++)
      stage_out[i] = pipe_data[i];
  end

  always_ff @(posedge clock) begin
    pipe_data[0] <= memory.m_data;
    pipe_write   <= memory.m_write;
    for (int i = 1; i < LATENCY; i++)
      pipe_data[i] <= stage_out[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++)
        pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  assign push = pipe_valid[LATENCY-1];

  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= stage_out[LATENCY-1];
  end

  // Pointers wrap modulo RESP_DEPTH; empty/full come from the counts, not pointer equality.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign memory.s_valid = (fifo_count != '0);
  assign memory.s_data  = memory.s_valid ? fifo_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_memory_slave.sv
// Directed plus randomized bench for memory_slave, checked against a queue-based
// model: each accepted request becomes a response due LATENCY edges later, served in order.
module tb_memory_slave;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  Memory #(.DATA_WIDTH(DW)) mem_if ();

  memory_slave #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LATENCY   (LAT),
    .RESP_DEPTH(DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .memory(mem_if.slave)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  int            checks = 0;
  int            errors = 0;
  int            edges  = 0;
  logic [DW-1:0] ref_ram [2**AW];
  resp_t         q [$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit rst, input bit valid, input bit wr, input logic [31:0] addr,
                      input logic [DW-1:0] data, input bit sready, output bit acc);
    bit            exp_ready;
    bit            exp_valid;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] idx;
    resp_t         r;
    reset            = rst;
    mem_if.m_valid   = valid;
    mem_if.m_write   = wr;
    mem_if.m_address = addr;
    mem_if.m_data    = data;
    mem_if.s_ready   = sready;
    #1;
    exp_ready = !rst && (q.size() < DEPTH);
    exp_valid = (q.size() > 0) && (q[0].due <= edges);
    exp_data  = exp_valid ? q[0].data : '0;
    check("m_ready", DW'(mem_if.m_ready), DW'(exp_ready));
    check("s_valid", DW'(mem_if.s_valid), DW'(exp_valid));
    if (exp_valid || rst)
      check("s_data", mem_if.s_data, exp_data);
    acc = valid && exp_ready;
    if (acc)
      $display("req %s addr=%h data=%h edge=%0d", wr ? "W" : "R", addr, wr ? data : ref_ram[addr[AW-1:0]], edges);
    @(posedge clock);
    edges++;
    if (rst) begin
      q.delete();
    end else begin
      if (exp_valid && sready)
        void'(q.pop_front());
      if (acc) begin
        idx = addr[AW-1:0];
        if (wr) begin
          ref_ram[idx] = data;
          r.data = data;
        end else begin
          r.data = ref_ram[idx];
        end
        r.due = edges + LAT;
        q.push_back(r);
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n, input bit sready);
    bit acc;
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 32'h0, '0, sready, acc);
  endtask

  task automatic send(input bit wr, input logic [31:0] addr, input logic [DW-1:0] data, input bit sready);
    bit acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++)
      step(1'b0, 1'b1, wr, addr, data, sready, acc);
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout: observed no accept, expected accept for addr %h", addr);
    end
  endtask

  initial begin
    bit acc;
    int k;
    mem_if.m_valid   = 1'b0;
    mem_if.m_write   = 1'b0;
    mem_if.m_address = '0;
    mem_if.m_data    = '0;
    mem_if.s_ready   = 1'b0;
    @(negedge clock);

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 32'h0, '0, 1'b1, acc);
    idle(2, 1'b1);

    // Preload every word with random data through back-to-back writes.
    for (int a = 0; a < 2**AW; a++)
      send(1'b1, 32'(a), DW'($urandom), 1'b1);
    idle(6, 1'b1);

    // Boot pattern: write via address -1, then read the top word.
    send(1'b1, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b1);
    send(1'b0, 32'(2**AW - 1), '0, 1'b1);
    idle(6, 1'b1);

    // Read immediately after write to the same address.
    send(1'b1, 32'h10, 32'h1234_5678, 1'b1);
    send(1'b0, 32'h10, '0, 1'b1);
    idle(6, 1'b1);

    // Backpressure: only DEPTH reads get in while s_ready is low, then drain across wraps.
    for (int a = 0; a < 8; a++)
      send(1'b1, 32'(a), DW'(a), 1'b1);
    idle(6, 1'b1);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'(k), '0, 1'b0, acc);
      if (acc) k++;
    end
    for (int i = 0; i < 40 && k < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'(k), '0, 1'b1, acc);
      if (acc) k++;
    end
    idle(8, 1'b1);

    // Accept and pop on the same edge with DEPTH-1 outstanding.
    for (int i = 0; i < 3; i++)
      send(1'b0, 32'(i + 3), '0, 1'b0);
    idle(4, 1'b0);
    send(1'b0, 32'h7, '0, 1'b1);
    idle(2, 1'b0);
    idle(8, 1'b1);

    // Reset pulse with three reads in flight; RAM contents must survive.
    for (int i = 0; i < 3; i++)
      send(1'b0, 32'(i), '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, '0, 1'b1, acc);
    idle(6, 1'b1);
    send(1'b0, 32'h10, '0, 1'b1);
    send(1'b0, 32'(2**AW - 1), '0, 1'b1);
    for (int i = 0; i < 4; i++)
      send(1'b0, 32'(i), '0, 1'b1);
    idle(6, 1'b1);

    // Random traffic with random backpressure and aliased addresses.
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, DW'($urandom),
           $urandom_range(0, 3) != 0, acc);
    idle(10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
